// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte-stream programmer for the instruction memory write port
module imem_loader #(
  parameter int PC_SIZE   = 10,
  parameter int PC_STEP   = 4,
  parameter int MAX_WORDS = 256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               rw,
  output logic [PC_SIZE-1:0] PC_write,
  output logic [31:0]        instruction_in,
  output logic               reset_IF_memory,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [16:0] LP_MAX = 17'(MAX_WORDS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_LEN_HI = 3'd3;
  localparam logic [2:0] S_BYTE   = 3'd4;
  localparam logic [2:0] S_WRITE  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]         r_state;
  logic [7:0]         r_len_lo;
  logic [CW-1:0]      r_remaining;
  logic [1:0]         r_idx;
  logic [23:0]        r_word;
  logic [PC_SIZE-1:0] r_addr;
  logic [PC_SIZE-1:0] r_pc_write;
  logic [31:0]        r_instr;
  logic               r_error;
  logic               w_xfer;
  logic [15:0]        w_len;

  assign byte_ready      = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_BYTE);
  assign w_xfer          = byte_ready && byte_valid;
  assign w_len           = {byte_in, r_len_lo};
  assign rw              = (r_state == S_WRITE);
  assign reset_IF_memory = (r_state == S_CLEAR);
  assign cpu_hold        = (r_state != S_IDLE);
  assign busy            = (r_state != S_IDLE);
  assign done            = (r_state == S_DONE);
  assign error           = r_error;
  assign PC_write        = r_pc_write;
  assign instruction_in  = r_instr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_len_lo    <= '0;
      r_remaining <= '0;
      r_idx       <= '0;
      r_word      <= '0;
      r_addr      <= '0;
      r_pc_write  <= '0;
      r_instr     <= '0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_CLEAR;
            r_error <= 1'b0;
            r_addr  <= '0;
          end
        end
        S_CLEAR: r_state <= S_LEN_LO;
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len_lo <= byte_in;
            r_state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            if (w_len == 16'd0) begin
              r_state <= S_DONE;
            end else if ({1'b0, w_len} > LP_MAX) begin
              r_error <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_remaining <= w_len[CW-1:0];
              r_idx       <= 2'd0;
              r_state     <= S_BYTE;
            end
          end
        end
        S_BYTE: begin
          if (w_xfer) begin
            r_idx <= r_idx + 2'd1;
            // Output registers load here so they are valid exactly on the WRITE cycle
            case (r_idx)
              2'd0: r_word[7:0]   <= byte_in;
              2'd1: r_word[15:8]  <= byte_in;
              2'd2: r_word[23:16] <= byte_in;
              2'd3: begin
                r_pc_write <= r_addr;
                r_instr    <= {byte_in, r_word};
                r_state    <= S_WRITE;
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
        S_WRITE: begin
          r_addr      <= r_addr + PC_SIZE'(PC_STEP);
          r_remaining <= r_remaining - CW'(1);
          r_idx       <= 2'd0;
          r_state     <= (r_remaining == CW'(1)) ? S_DONE : S_BYTE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a stream-level model
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready, rw, reset_IF_memory, cpu_hold, busy, done, error;
  logic [9:0]  PC_write;
  logic [31:0] instruction_in;

  imem_loader dut (
    .clock(clock), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .rw(rw), .PC_write(PC_write), .instruction_in(instruction_in),
    .reset_IF_memory(reset_IF_memory), .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int          n_pass = 0;
  int          n_total = 0;
  logic [7:0]  byte_q[$];
  logic [9:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  logic [9:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_err;
  int          clr_cnt = 0;
  int          done_cnt = 0;
  logic        obs_hold_in, obs_hold_after, obs_err_clear;
  bit          timed_out;
  int          busy_start_idx = -1;

  always @(negedge clock) begin
    if (rw) begin
      wr_addr.push_back(PC_write);
      wr_data.push_back(instruction_in);
    end
    if (reset_IF_memory) clr_cnt++;
    if (done) done_cnt++;
  end

  // Reference: length prefix, then little-endian words at consecutive 4-byte addresses
  task automatic build_model();
    int len;
    exp_addr.delete();
    exp_data.delete();
    len = int'(byte_q[0]) + 256 * int'(byte_q[1]);
    exp_err = (len > 256);
    if (!exp_err) begin
      for (int w = 0; w < len; w++) begin
        exp_addr.push_back(10'((w * 4) % 1024));
        exp_data.push_back({byte_q[2+4*w+3], byte_q[2+4*w+2], byte_q[2+4*w+1], byte_q[2+4*w]});
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    if (gap) begin
      byte_valid = 1'b0;
      @(posedge clock); #1;
    end
    byte_in = b;
    byte_valid = 1'b1;
    do begin
      @(negedge clock);
      n++;
    end while (!byte_ready && n < 40);
    if (!byte_ready) timed_out = 1;
    @(posedge clock); #1;
    byte_valid = 1'b0;
  endtask

  task automatic run_session(input bit gap);
    int n = 0;
    wr_addr.delete();
    wr_data.delete();
    clr_cnt = 0;
    done_cnt = 0;
    timed_out = 0;
    build_model();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    obs_hold_in = cpu_hold;
    obs_err_clear = error;
    for (int i = 0; i < byte_q.size(); i++) begin
      if (i == busy_start_idx) start = 1'b1;
      send_byte(byte_q[i], gap);
      start = 1'b0;
    end
    do begin
      @(negedge clock);
      n++;
    end while (!done && n < 40);
    if (!done) timed_out = 1;
    @(negedge clock);
    obs_hold_after = cpu_hold | busy;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_total++;
    if ({byte_ready, rw, reset_IF_memory, cpu_hold, busy, done, error, PC_write, instruction_in} !== '0)
      $display("FAIL reset_outputs got rdy=%b rw=%b clr=%b hold=%b busy=%b done=%b err=%b pc=%h ins=%h want all 0",
               byte_ready, rw, reset_IF_memory, cpu_hold, busy, done, error, PC_write, instruction_in);
    else n_pass++;
    reset = 1'b1;
    byte_in = 8'hAA;
    byte_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      n_total++;
      if ({byte_ready, rw} !== 2'b00) $display("FAIL idle_no_accept got rdy=%b rw=%b want 0 0", byte_ready, rw);
      else n_pass++;
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_two_word();
    byte_q = {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    run_session(0);
    n_total++;
    if (timed_out !== 0) $display("FAIL two_word_timeout got %0d want 0", timed_out); else n_pass++;
    n_total++;
    if (clr_cnt !== 1) $display("FAIL two_word_clear_pulses got %0d want 1", clr_cnt); else n_pass++;
    n_total++;
    if (done_cnt !== 1) $display("FAIL two_word_done_pulses got %0d want 1", done_cnt); else n_pass++;
    n_total++;
    if (wr_addr.size() !== 2) $display("FAIL two_word_write_count got %0d want 2", wr_addr.size()); else n_pass++;
    if (wr_addr.size() == 2) begin
      n_total++;
      if (wr_addr[0] !== 10'h000 || wr_data[0] !== 32'h00A00513)
        $display("FAIL two_word_w0 got %h:%h want 000:00a00513", wr_addr[0], wr_data[0]);
      else n_pass++;
      n_total++;
      if (wr_addr[1] !== 10'h004 || wr_data[1] !== 32'h00B00593)
        $display("FAIL two_word_w1 got %h:%h want 004:00b00593", wr_addr[1], wr_data[1]);
      else n_pass++;
    end
    n_total++;
    if (obs_hold_in !== 1'b1) $display("FAIL two_word_hold_set got %b want 1", obs_hold_in); else n_pass++;
    n_total++;
    if (obs_hold_after !== 1'b0) $display("FAIL two_word_hold_release got %b want 0", obs_hold_after); else n_pass++;
    n_total++;
    if (error !== 1'b0) $display("FAIL two_word_error got %b want 0", error); else n_pass++;
  endtask

  task automatic test_backpressure();
    byte_q = {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    run_session(1);
    n_total++;
    if (timed_out !== 0) $display("FAIL gaps_timeout got %0d want 0", timed_out); else n_pass++;
    n_total++;
    if (wr_addr.size() !== exp_addr.size())
      $display("FAIL gaps_write_count got %0d want %0d", wr_addr.size(), exp_addr.size());
    else n_pass++;
    for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
      n_total++;
      if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i])
        $display("FAIL gaps_write%0d got %h:%h want %h:%h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
      else n_pass++;
    end
  endtask

  task automatic test_len_zero();
    byte_q = {8'h00, 8'h00};
    run_session(0);
    n_total++;
    if (done_cnt !== 1 || timed_out !== 0) $display("FAIL len0_done got %0d to=%0d want 1 0", done_cnt, timed_out);
    else n_pass++;
    n_total++;
    if (wr_addr.size() !== 0) $display("FAIL len0_writes got %0d want 0", wr_addr.size()); else n_pass++;
    n_total++;
    if (error !== 1'b0) $display("FAIL len0_error got %b want 0", error); else n_pass++;
  endtask

  task automatic test_len_over();
    byte_q = {8'h01, 8'h01};
    run_session(0);
    n_total++;
    if (done_cnt !== 1 || timed_out !== 0) $display("FAIL len_over_done got %0d to=%0d want 1 0", done_cnt, timed_out);
    else n_pass++;
    n_total++;
    if (wr_addr.size() !== 0) $display("FAIL len_over_writes got %0d want 0", wr_addr.size()); else n_pass++;
    n_total++;
    if (error !== exp_err) $display("FAIL len_over_error got %b want %b", error, exp_err); else n_pass++;
    repeat (5) @(negedge clock);
    n_total++;
    if (error !== 1'b1) $display("FAIL len_over_sticky got %b want 1", error); else n_pass++;
  endtask

  task automatic test_len_max();
    byte_q = {8'h00, 8'h01};
    for (int i = 0; i < 1024; i++) byte_q.push_back(8'($urandom));
    run_session(0);
    n_total++;
    if (obs_err_clear !== 1'b0) $display("FAIL len_max_error_cleared got %b want 0", obs_err_clear); else n_pass++;
    n_total++;
    if (timed_out !== 0) $display("FAIL len_max_timeout got %0d want 0", timed_out); else n_pass++;
    n_total++;
    if (wr_addr.size() !== 256 || wr_addr[255] !== 10'h3FC)
      $display("FAIL len_max_last_addr got n=%0d addr=%h want 256 3fc", wr_addr.size(), wr_addr[wr_addr.size()-1]);
    else n_pass++;
    for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
      n_total++;
      if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i])
        $display("FAIL len_max_write%0d got %h:%h want %h:%h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    wr_addr.delete();
    wr_data.delete();
    timed_out = 0;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    n_total++;
    if ({byte_ready, rw, reset_IF_memory, cpu_hold, busy, done, error, PC_write, instruction_in} !== '0)
      $display("FAIL mid_reset_outputs got hold=%b busy=%b rw=%b pc=%h ins=%h want all 0",
               cpu_hold, busy, rw, PC_write, instruction_in);
    else n_pass++;
    byte_in = 8'h33;
    byte_valid = 1'b1;
    repeat (3) @(negedge clock);
    byte_valid = 1'b0;
    n_total++;
    if (wr_addr.size() !== 0) $display("FAIL mid_reset_no_write got %0d want 0", wr_addr.size()); else n_pass++;
    byte_q = {8'h01, 8'h00, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    run_session(0);
    n_total++;
    if (wr_addr.size() !== 1 || wr_addr[0] !== 10'h000 || wr_data[0] !== exp_data[0])
      $display("FAIL mid_reset_fresh got n=%0d %h:%h want 1 000:%h", wr_addr.size(), wr_addr[0], wr_data[0], exp_data[0]);
    else n_pass++;
  endtask

  task automatic test_start_busy();
    byte_q = {8'h02, 8'h00};
    for (int i = 0; i < 8; i++) byte_q.push_back(8'($urandom));
    busy_start_idx = 4;
    run_session(0);
    busy_start_idx = -1;
    n_total++;
    if (clr_cnt !== 1) $display("FAIL start_busy_clear_pulses got %0d want 1", clr_cnt); else n_pass++;
    n_total++;
    if (done_cnt !== 1 || timed_out !== 0) $display("FAIL start_busy_done got %0d to=%0d want 1 0", done_cnt, timed_out);
    else n_pass++;
    n_total++;
    if (wr_addr.size() !== exp_addr.size())
      $display("FAIL start_busy_write_count got %0d want %0d", wr_addr.size(), exp_addr.size());
    else n_pass++;
    for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
      n_total++;
      if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i])
        $display("FAIL start_busy_write%0d got %h:%h want %h:%h", i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int nw;
    for (int s = 0; s < 5; s++) begin
      nw = $urandom_range(1, 6);
      byte_q = {8'(nw), 8'h00};
      for (int i = 0; i < 4 * nw; i++) byte_q.push_back(8'($urandom));
      run_session(bit'($urandom_range(0, 1)));
      n_total++;
      if (done_cnt !== 1 || clr_cnt !== 1 || timed_out !== 0)
        $display("FAIL random%0d_session got done=%0d clr=%0d to=%0d want 1 1 0", s, done_cnt, clr_cnt, timed_out);
      else n_pass++;
      n_total++;
      if (wr_addr.size() !== exp_addr.size())
        $display("FAIL random%0d_write_count got %0d want %0d", s, wr_addr.size(), exp_addr.size());
      else n_pass++;
      for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
        n_total++;
        if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i])
          $display("FAIL random%0d_write%0d got %h:%h want %h:%h", s, i, wr_addr[i], wr_data[i], exp_addr[i], exp_data[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_backpressure();
    test_len_zero();
    test_len_over();
    test_len_max();
    test_mid_reset();
    test_start_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got still running want finished");
    $fatal(1);
  end

endmodule
